// File: rtl/tim_sched_pkg.sv
// Shared types and helpers for the tim_sched timer scheduler.
// Optional feature macro: TIM_SCHED_CANCEL_EN (adds the cancel input).
package tim_sched_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Arbiter is written for the widest supported requester count
    localparam int RR_MAX   = 16;
    localparam int RR_IDX_W = $clog2(RR_MAX);

    // Round-robin pick: rotate so the search starts at last+1, take the first
    // set bit in rotated order, and map that position back to a real index.
    // Returns last when nothing is requested; callers gate with |req_vec.
    function automatic logic [RR_IDX_W-1:0] rr_pick(
        input logic [RR_MAX-1:0]   req_vec,
        input logic [RR_IDX_W-1:0] last,
        input logic [RR_IDX_W:0]   nreq
    );
        logic [RR_IDX_W-1:0] pick;
        logic [RR_IDX_W-1:0] idx;
        logic [RR_IDX_W+1:0] sum;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= RR_MAX; k++) begin
            sum = {2'b00, last} + (RR_IDX_W+2)'(k);
            // last < nreq and k <= nreq, so one subtraction completes the modulo
            sum = (sum >= {1'b0, nreq}) ? (sum - {1'b0, nreq}) : sum;
            idx = sum[RR_IDX_W-1:0];
            if (!found && ((RR_IDX_W+1)'(k) <= nreq) && req_vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tim_core.sv
// One-shot N-bit down-counter shared by all requesters of tim_sched.
// start loads load_val (run length minus one); expire marks the final cycle.
module tim_core
    import tim_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] load_val,
    output logic         running,
    output logic         expire
);

    logic [N-1:0] cnt_r;
    logic         running_r;

    // Counter: reload on start, otherwise count down to zero and stop there
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= {N{1'b0}};
            running_r <= 1'b0;
        end else if (start) begin
            cnt_r     <= load_val;
            running_r <= 1'b1;
        end else if (running_r) begin
            if (cnt_r == {N{1'b0}}) begin
                running_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - N'(1);
            end
        end else begin
            cnt_r     <= cnt_r;
            running_r <= running_r;
        end
    end

    assign running = running_r;
    assign expire  = running_r && (cnt_r == {N{1'b0}});

endmodule

// File: rtl/tim_sched.sv
// Round-robin scheduler sharing one one-shot timer among NREQ requesters.
// Optional feature macro: TIM_SCHED_CANCEL_EN adds a cancel input that aborts
// the current run without a done pulse.
module tim_sched
    import tim_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*N-1:0]       load,
`ifdef TIM_SCHED_CANCEL_EN
    input  logic                    cancel,
`endif
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         done,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] active_id
);

    localparam int ID_W = $clog2(NREQ);

    state_e              state_r;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     done_r;
    logic                busy_r;
    logic [ID_W-1:0]     active_id_r;
    logic [ID_W-1:0]     last_r;

    logic [RR_MAX-1:0]   req_pad_s;
    logic [RR_IDX_W-1:0] win_full_s;
    logic [ID_W-1:0]     win_s;
    logic [NREQ-1:0]     win_oh_s;
    logic [NREQ-1:0]     id_oh_s;
    logic [N-1:0]        sel_load_s;
    logic [N-1:0]        load_val_s;
    logic                start_s;
    logic                core_running_s;
    logic                core_expire_s;

    // Arbitration: widen req to the arbiter width and pick the next winner
    always_comb begin
        req_pad_s = {RR_MAX{1'b0}};
        req_pad_s[NREQ-1:0] = req;
        win_full_s = rr_pick(req_pad_s, RR_IDX_W'(last_r), (RR_IDX_W+1)'(NREQ));
        win_s = ID_W'(win_full_s);
    end

    // One-hot forms of the winner and of the current owner
    always_comb begin
        win_oh_s = {NREQ{1'b0}};
        win_oh_s[win_s] = 1'b1;
        id_oh_s = {NREQ{1'b0}};
        id_oh_s[active_id_r] = 1'b1;
    end

    // Winner's load; zero is promoted to a one-cycle run, counter gets L-1
    always_comb begin
        sel_load_s = {N{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_load_s = (ID_W'(i) == win_s) ? load[i*N +: N] : sel_load_s;
        end
        if (sel_load_s == {N{1'b0}}) begin
            load_val_s = {N{1'b0}};
        end else begin
            load_val_s = sel_load_s - N'(1);
        end
    end

    assign start_s = (state_r == ST_IDLE) && (|req);

    tim_core #(
        .N (N)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (start_s),
        .load_val (load_val_s),
        .running  (core_running_s),
        .expire   (core_expire_s)
    );

    // Scheduler FSM with registered grant, done, busy and owner outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt_r       <= {NREQ{1'b0}};
            done_r      <= {NREQ{1'b0}};
            busy_r      <= 1'b0;
            active_id_r <= {ID_W{1'b0}};
            last_r      <= ID_W'(NREQ - 1);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= {NREQ{1'b0}};
                    if (start_s) begin
                        gnt_r       <= win_oh_s;
                        busy_r      <= 1'b1;
                        active_id_r <= win_s;
                        last_r      <= win_s;
                        state_r     <= ST_RUN;
                    end else begin
                        gnt_r   <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
`ifdef TIM_SCHED_CANCEL_EN
                    if (cancel) begin
                        gnt_r   <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else
`endif
                    // A stopped core while in RUN is treated as expiry so the FSM cannot hang
                    if (core_expire_s || !core_running_s) begin
                        gnt_r   <= {NREQ{1'b0}};
                        done_r  <= id_oh_s;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_r  <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    gnt_r   <= {NREQ{1'b0}};
                    done_r  <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign active_id = active_id_r;

endmodule

// File: tb/tb_tim_sched.sv
// Directed self-checking bench for tim_sched (NREQ=4, N=4).
// The cancel scenario is compiled in when TIM_SCHED_CANCEL_EN is defined.
module tb_tim_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [15:0] load = 16'h0000;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic [1:0]  active_id;
`ifdef TIM_SCHED_CANCEL_EN
    logic        cancel = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    tim_sched #(
        .NREQ (4),
        .N    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .load      (load),
`ifdef TIM_SCHED_CANCEL_EN
        .cancel    (cancel),
`endif
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .active_id (active_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First step is the grant edge; expects len grant cycles, one done cycle, then idle
    task automatic expect_run(input logic [3:0] g, input int len, input logic [1:0] id, input int drop_at);
        for (int k = 0; k < len; k++) begin
            step();
            chk("gnt_run",  32'(gnt),       32'(g));
            chk("done_run", 32'(done),      32'd0);
            chk("busy_run", 32'(busy),      32'd1);
            chk("id_run",   32'(active_id), 32'(id));
            if (k == drop_at) req = 4'b0000;
        end
        step();
        chk("gnt_fall",   32'(gnt),       32'd0);
        chk("done_pulse", 32'(done),      32'(g));
        chk("busy_done",  32'(busy),      32'd1);
        chk("id_done",    32'(active_id), 32'(id));
        step();
        chk("gnt_idle",  32'(gnt),  32'd0);
        chk("done_idle", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        rst = 1'b0;
        chk("rst_gnt",  32'(gnt),       32'd0);
        chk("rst_done", 32'(done),      32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_id",   32'(active_id), 32'd0);

        // Single request: requester 1, load 5
        load[7:4] = 4'd5;
        req = 4'b0010;
        expect_run(4'b0010, 5, 2'd1, -1);
        req = 4'b0000;

        // Contention from reset: order 0,1,2,3,0 with load 2 each
        rst = 1'b1;
        step();
        rst = 1'b0;
        load = 16'h2222;
        req = 4'b1111;
        expect_run(4'b0001, 2, 2'd0, -1);
        expect_run(4'b0010, 2, 2'd1, -1);
        expect_run(4'b0100, 2, 2'd2, -1);
        expect_run(4'b1000, 2, 2'd3, -1);
        expect_run(4'b0001, 2, 2'd0, 0);

        // Load 0 runs for exactly one cycle
        load = 16'h0000;
        req = 4'b0100;
        expect_run(4'b0100, 1, 2'd2, -1);
        req = 4'b0000;

        // Request dropped after the first run cycle: run still completes
        load[15:12] = 4'd3;
        req = 4'b1000;
        expect_run(4'b1000, 3, 2'd3, 0);

        // Reset on the 4th run cycle, then a fresh full run
        load = 16'h0000;
        load[3:0] = 4'd9;
        req = 4'b0001;
        step();
        chk("mr_gnt", 32'(gnt), 32'd1);
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("mr_gnt_clr",  32'(gnt),       32'd0);
        chk("mr_done_clr", 32'(done),      32'd0);
        chk("mr_busy_clr", 32'(busy),      32'd0);
        chk("mr_id_clr",   32'(active_id), 32'd0);
        step();
        chk("mr_done_hold", 32'(done), 32'd0);
        rst = 1'b0;
        expect_run(4'b0001, 9, 2'd0, -1);
        req = 4'b0000;

`ifdef TIM_SCHED_CANCEL_EN
        // Cancel on the 3rd run cycle; pending requester 1 granted two edges later
        rst = 1'b1;
        step();
        rst = 1'b0;
        load = 16'h0000;
        load[3:0] = 4'd8;
        load[7:4] = 4'd3;
        req = 4'b0001;
        step();
        chk("cn_gnt", 32'(gnt), 32'd1);
        step();
        step();
        cancel = 1'b1;
        req = 4'b0010;
        step();
        cancel = 1'b0;
        chk("cn_gnt_clr",  32'(gnt),  32'd0);
        chk("cn_no_done",  32'(done), 32'd0);
        chk("cn_busy_clr", 32'(busy), 32'd0);
        expect_run(4'b0010, 3, 2'd1, -1);
        req = 4'b0000;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
